// File: rtl/riscv_idu.sv
// RV32I instruction decode unit: PC tracking, field decode and a two-entry skid buffer toward execute.
// Optional M-extension decode is enabled by defining RISCV_IDU_MEXT_EN.
module riscv_idu (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        clear_i,
    input  logic [29:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        instr_valid_i,
    output logic        instr_ready_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [29:0] pc_o,
    output logic [3:0]  op_o,
    output logic [2:0]  funct3_o,
    output logic        alt_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [31:0] imm_o,
    output logic        illegal_o
);

    localparam logic [3:0] OP_LUI     = 4'd0;
    localparam logic [3:0] OP_AUIPC   = 4'd1;
    localparam logic [3:0] OP_JAL     = 4'd2;
    localparam logic [3:0] OP_JALR    = 4'd3;
    localparam logic [3:0] OP_BRANCH  = 4'd4;
    localparam logic [3:0] OP_LOAD    = 4'd5;
    localparam logic [3:0] OP_STORE   = 4'd6;
    localparam logic [3:0] OP_OPIMM   = 4'd7;
    localparam logic [3:0] OP_OP      = 4'd8;
    localparam logic [3:0] OP_FENCE   = 4'd9;
    localparam logic [3:0] OP_SYSTEM  = 4'd10;
`ifdef RISCV_IDU_MEXT_EN
    localparam logic [3:0] OP_MULDIV  = 4'd11;
`endif
    localparam logic [3:0] OP_ILLEGAL = 4'd15;

    logic        ready_reg;
    logic        out_valid_reg, out_valid_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_instr_reg;
    logic [29:0] skid_pc_reg;
    logic [29:0] pc_cnt_reg, pc_cnt_next;
    logic        out_load, skid_load;

    logic [29:0] pc_reg;
    logic [3:0]  op_reg;
    logic [2:0]  funct3_reg;
    logic        alt_reg;
    logic [4:0]  rd_reg, rs1_reg, rs2_reg;
    logic [31:0] imm_reg;

    logic accept, out_free;
    assign accept   = instr_valid_i && ready_reg;
    assign out_free = !out_valid_reg || ready_i;

    // OUT is always refilled from SKID first so ordering is preserved.
    logic [31:0] dec_instr;
    logic [29:0] dec_pc;
    assign dec_instr = skid_valid_reg ? skid_instr_reg : instr_i;
    assign dec_pc    = skid_valid_reg ? skid_pc_reg    : pc_cnt_reg;

    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  dec_op;
    logic [31:0] dec_imm;

    assign opc   = dec_instr[6:0];
    assign f3    = dec_instr[14:12];
    assign f7    = dec_instr[31:25];
    assign imm_i = {{20{dec_instr[31]}}, dec_instr[31:20]};
    assign imm_s = {{20{dec_instr[31]}}, dec_instr[31:25], dec_instr[11:7]};
    assign imm_b = {{19{dec_instr[31]}}, dec_instr[31], dec_instr[7], dec_instr[30:25],
                    dec_instr[11:8], 1'b0};
    assign imm_u = {dec_instr[31:12], 12'b0};
    assign imm_j = {{11{dec_instr[31]}}, dec_instr[31], dec_instr[19:12], dec_instr[20],
                    dec_instr[30:21], 1'b0};

    always_comb begin
        dec_op  = OP_ILLEGAL;
        dec_imm = 32'd0;
        case (opc)
            7'b0110111: begin dec_op = OP_LUI;   dec_imm = imm_u; end
            7'b0010111: begin dec_op = OP_AUIPC; dec_imm = imm_u; end
            7'b1101111: begin dec_op = OP_JAL;   dec_imm = imm_j; end
            7'b1100111: if (f3 == 3'b000) begin
                dec_op = OP_JALR; dec_imm = imm_i;
            end
            7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
                dec_op = OP_BRANCH; dec_imm = imm_b;
            end
            7'b0000011: if (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) begin
                dec_op = OP_LOAD; dec_imm = imm_i;
            end
            7'b0100011: if (f3 < 3'b011) begin
                dec_op = OP_STORE; dec_imm = imm_s;
            end
            7'b0010011: begin
                // Shift-immediates carry funct7 in the immediate field and must be checked.
                if ((f3 == 3'b001 && f7 != 7'b0000000) ||
                    (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)) begin
                    dec_op = OP_ILLEGAL;
                end else begin
                    dec_op = OP_OPIMM; dec_imm = imm_i;
                end
            end
            7'b0110011: begin
                if (f7 == 7'b0000000 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec_op = OP_OP;
                end
`ifdef RISCV_IDU_MEXT_EN
                else if (f7 == 7'b0000001) begin
                    dec_op = OP_MULDIV;
                end
`endif
            end
            7'b0001111: begin dec_op = OP_FENCE;  dec_imm = imm_i; end
            7'b1110011: begin dec_op = OP_SYSTEM; dec_imm = imm_i; end
            default: begin
                dec_op  = OP_ILLEGAL;
                dec_imm = 32'd0;
            end
        endcase
    end

    // SKID can only be loaded while empty, since ready_reg tracks SKID emptiness.
    always_comb begin
        out_valid_next  = out_valid_reg;
        skid_valid_next = skid_valid_reg;
        out_load        = 1'b0;
        skid_load       = 1'b0;
        pc_cnt_next     = accept ? pc_cnt_reg + 30'd1 : pc_cnt_reg;
        if (out_free) begin
            if (skid_valid_reg) begin
                out_load        = 1'b1;
                out_valid_next  = 1'b1;
                skid_load       = accept;
                skid_valid_next = accept;
            end else begin
                out_load       = accept;
                out_valid_next = accept;
            end
        end else if (accept) begin
            skid_load       = 1'b1;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            ready_reg      <= 1'b1;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= 32'd0;
            skid_pc_reg    <= 30'd0;
            pc_cnt_reg     <= 30'd0;
            pc_reg         <= 30'd0;
            op_reg         <= 4'd0;
            funct3_reg     <= 3'd0;
            alt_reg        <= 1'b0;
            rd_reg         <= 5'd0;
            rs1_reg        <= 5'd0;
            rs2_reg        <= 5'd0;
            imm_reg        <= 32'd0;
        end else if (clear_i) begin
            ready_reg      <= 1'b1;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            pc_cnt_reg     <= pc_i;
        end else begin
            ready_reg      <= !skid_valid_next;
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            pc_cnt_reg     <= pc_cnt_next;
            if (skid_load) begin
                skid_instr_reg <= instr_i;
                skid_pc_reg    <= pc_cnt_reg;
            end
            if (out_load) begin
                pc_reg     <= dec_pc;
                op_reg     <= dec_op;
                funct3_reg <= dec_instr[14:12];
                alt_reg    <= dec_instr[30];
                rd_reg     <= dec_instr[11:7];
                rs1_reg    <= dec_instr[19:15];
                rs2_reg    <= dec_instr[24:20];
                imm_reg    <= dec_imm;
            end
        end
    end

    assign instr_ready_o = ready_reg;
    assign valid_o       = out_valid_reg;
    assign pc_o          = pc_reg;
    assign op_o          = op_reg;
    assign funct3_o      = funct3_reg;
    assign alt_o         = alt_reg;
    assign rd_o          = rd_reg;
    assign rs1_o         = rs1_reg;
    assign rs2_o         = rs2_reg;
    assign imm_o         = imm_reg;
    assign illegal_o     = (op_reg == OP_ILLEGAL);

endmodule

// File: tb/tb_riscv_idu.sv
// Scoreboard bench for riscv_idu: expected decodes are queued on accept and compared on consume.
module tb_riscv_idu;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic [29:0] pc_i = 30'd0;
    logic [31:0] instr_i = 32'd0;
    logic        instr_valid_i = 1'b0;
    logic        instr_ready_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [29:0] pc_o;
    logic [3:0]  op_o;
    logic [2:0]  funct3_o;
    logic        alt_o;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    riscv_idu dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .clear_i(clear_i), .pc_i(pc_i),
        .instr_i(instr_i), .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .op_o(op_o),
        .funct3_o(funct3_o), .alt_o(alt_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .imm_o(imm_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef RISCV_IDU_MEXT_EN
    localparam logic [3:0] MUL_OP = 4'd11;
`else
    localparam logic [3:0] MUL_OP = 4'd15;
`endif

    typedef struct packed {
        logic [29:0] pc;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } exp_t;

    exp_t        sb_q[$];
    logic [29:0] pc_model = 30'd0;
    int          tests_run = 0;
    int          tests_failed = 0;
    bit          rand_ready = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [29:0] pc, input logic [31:0] i);
        exp_t e;
        logic ok;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        e.pc = pc; e.f3 = f3; e.alt = i[30];
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.op = 4'd15; e.imm = 32'd0; ok = 1'b1;
        case (i[6:0])
            7'h37: begin e.op = 4'd0; e.imm = {i[31:12], 12'h000}; end
            7'h17: begin e.op = 4'd1; e.imm = {i[31:12], 12'h000}; end
            7'h6F: begin e.op = 4'd2;
                e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'h67: begin e.op = 4'd3; e.imm = {{20{i[31]}}, i[31:20]}; ok = (f3 == 3'd0); end
            7'h63: begin e.op = 4'd4;
                e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                ok = !(f3 == 3'd2 || f3 == 3'd3); end
            7'h03: begin e.op = 4'd5; e.imm = {{20{i[31]}}, i[31:20]};
                ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
            7'h23: begin e.op = 4'd6; e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; ok = (f3 <= 3'd2); end
            7'h13: begin e.op = 4'd7; e.imm = {{20{i[31]}}, i[31:20]};
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20); end
            7'h33: begin
                if (f7 == 7'h01) e.op = MUL_OP;
                else begin
                    e.op = 4'd8;
                    ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                end
            end
            7'h0F: begin e.op = 4'd9;  e.imm = {{20{i[31]}}, i[31:20]}; end
            7'h73: begin e.op = 4'd10; e.imm = {{20{i[31]}}, i[31:20]}; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin e.op = 4'd15; e.imm = 32'd0; end
        return e;
    endfunction

    // Evaluate this cycle's handshakes on settled values, then advance one clock.
    task automatic cycle();
        exp_t e;
        if (rand_ready) ready_i = 1'($urandom_range(0, 1));
        if (!reset_ni) begin
            sb_q.delete();
            pc_model = 30'd0;
        end else if (clear_i) begin
            sb_q.delete();
            pc_model = pc_i;
        end else begin
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 32'(valid_o), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    $display("[TB] out pc=0x%08h op=%0d imm=0x%08h", pc_o, op_o, imm_o);
                    chk("pc", 32'(pc_o), 32'(e.pc));
                    chk("op", 32'(op_o), 32'(e.op));
                    chk("funct3", 32'(funct3_o), 32'(e.f3));
                    chk("alt", 32'(alt_o), 32'(e.alt));
                    chk("rd", 32'(rd_o), 32'(e.rd));
                    chk("rs1", 32'(rs1_o), 32'(e.rs1));
                    chk("rs2", 32'(rs2_o), 32'(e.rs2));
                    chk("imm", imm_o, e.imm);
                    chk("illegal", 32'(illegal_o), 32'(e.op == 4'd15));
                end
            end
            if (instr_valid_i && instr_ready_o) begin
                sb_q.push_back(model(pc_model, instr_i));
                pc_model = pc_model + 30'd1;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] ins);
        bit acc;
        acc = 0;
        instr_i = ins;
        instr_valid_i = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = instr_ready_o;
            cycle();
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        instr_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb_q.size() > 0; k++) cycle();
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        cycle();
        cycle();
        reset_ni = 1'b1;
    endtask

    logic [31:0] dir_ins [6] = '{32'hFE000EE3, 32'h0040006F, 32'h12345037,
                                 32'h40208033, 32'h00000000, 32'h02208033};
    logic [3:0]  dir_op  [6] = '{4'd4, 4'd2, 4'd0, 4'd8, 4'd15, MUL_OP};
    logic [31:0] dir_imm [6] = '{32'hFFFFFFFC, 32'h00000004, 32'h12345000,
                                 32'h0, 32'h0, 32'h0};
    logic [6:0]  opc_tab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
    logic [6:0]  f7_tab  [4] = '{7'h00, 7'h20, 7'h01, 7'h5A};

    initial begin
        logic [31:0] r;
        // Reset state
        #1;
        do_reset();
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_imm", imm_o, 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);

        // Single instruction, one-cycle latency
        ready_i = 1'b1;
        send(32'h00500093);
        chk("t1_valid", 32'(valid_o), 32'd1);
        chk("t1_op", 32'(op_o), 32'd7);
        chk("t1_rd", 32'(rd_o), 32'd1);
        chk("t1_imm", imm_o, 32'd5);
        chk("t1_pc", 32'(pc_o), 32'd0);
        drain();

        // Back-pressure fills both entries; third instruction held
        do_reset();
        ready_i = 1'b0;
        send(32'h00100113);
        chk("t2_ready_1", 32'(instr_ready_o), 32'd1);
        send(32'h00208193);
        chk("t2_ready_2", 32'(instr_ready_o), 32'd0);
        instr_i = 32'h00318213;
        instr_valid_i = 1'b1;
        cycle();
        cycle();
        chk("t2_held_ready", 32'(instr_ready_o), 32'd0);
        chk("t2_held_pc", 32'(pc_o), 32'd0);
        ready_i = 1'b1;
        send(32'h00318213);
        drain();

        // Clear with both entries full
        ready_i = 1'b0;
        send(32'h00100113);
        send(32'h00208193);
        chk("t3_full", 32'(instr_ready_o), 32'd0);
        clear_i = 1'b1;
        pc_i = 30'h100;
        cycle();
        clear_i = 1'b0;
        chk("t3_valid", 32'(valid_o), 32'd0);
        chk("t3_ready", 32'(instr_ready_o), 32'd1);
        ready_i = 1'b1;
        send(32'h00500093);
        chk("t3_pc", 32'(pc_o), 32'h100);
        drain();

        // Directed decode vectors
        for (int k = 0; k < 6; k++) begin
            send(dir_ins[k]);
            chk($sformatf("dir%0d_op", k), 32'(op_o), 32'(dir_op[k]));
            chk($sformatf("dir%0d_imm", k), imm_o, dir_imm[k]);
            chk($sformatf("dir%0d_illegal", k), 32'(illegal_o), 32'(dir_op[k] == 4'd15));
            drain();
        end

        // Random instruction stream with random execute back-pressure
        rand_ready = 1;
        for (int k = 0; k < 80; k++) begin
            r = $urandom;
            r[6:0] = opc_tab[$urandom_range(0, 11)];
            if ($urandom_range(0, 1) == 1) r[31:25] = f7_tab[$urandom_range(0, 3)];
            send(r);
        end
        rand_ready = 0;
        ready_i = 1'b1;
        drain();

        // Reset with both entries full and counter at 7
        clear_i = 1'b1;
        pc_i = 30'd5;
        cycle();
        clear_i = 1'b0;
        ready_i = 1'b0;
        send(32'h00100113);
        send(32'h00208193);
        reset_ni = 1'b0;
        cycle();
        reset_ni = 1'b1;
        chk("t6_valid", 32'(valid_o), 32'd0);
        chk("t6_ready", 32'(instr_ready_o), 32'd1);
        ready_i = 1'b1;
        send(32'h00500093);
        chk("t6_pc", 32'(pc_o), 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
